// File: rtl/model_convolutional_lstm_cell_update.sv
// model_convolutional_lstm_cell_update: streaming LSTM c/h update, c = f*c_in + i*a, h = o*act(c),
// signed fixed point with saturation, selectable hard-tanh/identity activation and sticky overflow.
module model_convolutional_lstm_cell_update #(
   parameter int DATA_SIZE     = 64,
   parameter int CONTROL_SIZE  = 4,
   parameter int FRACTION_SIZE = 32
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic                    READY,
   input  logic [DATA_SIZE-1:0]    SIZE_L_IN,
   input  logic [CONTROL_SIZE-1:0] MODE_IN,
   output logic                    L_OUT_ENABLE,
   input  logic                    L_IN_ENABLE,
   input  logic [DATA_SIZE-1:0]    I_IN,
   input  logic [DATA_SIZE-1:0]    F_IN,
   input  logic [DATA_SIZE-1:0]    O_IN,
   input  logic [DATA_SIZE-1:0]    A_IN,
   input  logic [DATA_SIZE-1:0]    C_IN,
   output logic [DATA_SIZE-1:0]    C_OUT,
   output logic                    C_OUT_ENABLE,
   output logic [DATA_SIZE-1:0]    H_OUT,
   output logic                    H_OUT_ENABLE,
   output logic                    OVERFLOW
);
   localparam int W = 2 * DATA_SIZE;
   localparam logic signed [DATA_SIZE-1:0] ONE = {{(DATA_SIZE-FRACTION_SIZE-1){1'b0}}, 1'b1, {FRACTION_SIZE{1'b0}}};
   localparam logic signed [DATA_SIZE-1:0] NEG_ONE = -ONE;
   typedef enum logic [2:0] {IDLE, INPUT_STATE, CELL_STATE, HIDDEN_STATE, ENDER} state_t;
   state_t state;
   logic [DATA_SIZE-1:0] size_l, index;
   logic mode;
   logic signed [DATA_SIZE-1:0] i_r, f_r, o_r, a_r, c_r, act;
   logic signed [W-1:0] p1, p2, ph;
   logic [DATA_SIZE:0] c_sat, h_sat;
   logic unused_mode;
   // Returns {overflow, clamped value}; overflow when the bits above the result sign disagree.
   function automatic logic [DATA_SIZE:0] sat(input logic [W:0] x);
      logic ovf;
      ovf = !(&x[W:DATA_SIZE-1] || ~|x[W:DATA_SIZE-1]);
      return {ovf, ovf ? {x[W], {(DATA_SIZE-1){~x[W]}}} : x[DATA_SIZE-1:0]};
   endfunction
   assign p1 = (W'(f_r) * W'(c_r)) >>> FRACTION_SIZE;
   assign p2 = (W'(i_r) * W'(a_r)) >>> FRACTION_SIZE;
   assign c_sat = sat({p1[W-1], p1} + {p2[W-1], p2});
   assign act = mode ? $signed(C_OUT) :
                $signed(C_OUT) > ONE ? ONE : $signed(C_OUT) < NEG_ONE ? NEG_ONE : $signed(C_OUT);
   assign ph = (W'(o_r) * W'(act)) >>> FRACTION_SIZE;
   assign h_sat = sat({ph[W-1], ph});
   assign unused_mode = ^MODE_IN[CONTROL_SIZE-1:1];
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         READY <= 1'b0;
         L_OUT_ENABLE <= 1'b0;
         C_OUT_ENABLE <= 1'b0;
         H_OUT_ENABLE <= 1'b0;
         OVERFLOW <= 1'b0;
         C_OUT <= '0;
         H_OUT <= '0;
         size_l <= '0;
         index <= '0;
         mode <= 1'b0;
         {i_r, f_r, o_r, a_r, c_r} <= '0;
      end else begin
         READY <= 1'b0;
         L_OUT_ENABLE <= 1'b0;
         C_OUT_ENABLE <= 1'b0;
         H_OUT_ENABLE <= 1'b0;
         case (state)
            IDLE: if (START) begin
               size_l <= SIZE_L_IN;
               mode <= MODE_IN[0];
               index <= '0;
               OVERFLOW <= 1'b0;
               L_OUT_ENABLE <= SIZE_L_IN != '0;
               state <= SIZE_L_IN == '0 ? ENDER : INPUT_STATE;
            end
            INPUT_STATE: if (L_IN_ENABLE) begin
               {i_r, f_r, o_r, a_r, c_r} <= {I_IN, F_IN, O_IN, A_IN, C_IN};
               state <= CELL_STATE;
            end
            CELL_STATE: begin
               C_OUT <= c_sat[DATA_SIZE-1:0];
               C_OUT_ENABLE <= 1'b1;
               OVERFLOW <= OVERFLOW | c_sat[DATA_SIZE];
               state <= HIDDEN_STATE;
            end
            HIDDEN_STATE: begin
               H_OUT <= h_sat[DATA_SIZE-1:0];
               H_OUT_ENABLE <= 1'b1;
               OVERFLOW <= OVERFLOW | h_sat[DATA_SIZE];
               if (index == size_l - DATA_SIZE'(1)) state <= ENDER;
               else begin
                  index <= index + DATA_SIZE'(1);
                  L_OUT_ENABLE <= 1'b1;
                  state <= INPUT_STATE;
               end
            end
            ENDER: begin
               READY <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_model_convolutional_lstm_cell_update.sv
// tb_model_convolutional_lstm_cell_update: randomized bench with a longint reference model of the
// LSTM update (DATA_SIZE=32, FRACTION_SIZE=16), checking values, pulse timing, overflow and reset abort.
module tb_model_convolutional_lstm_cell_update;
   localparam longint MAXV = 2147483647;
   localparam longint MINV = -MAXV - 1;
   logic clk = 0, rst = 1, start = 0, l_in_en = 0;
   logic ready, l_out_en, c_en, h_en, ovf;
   logic [31:0] size_l = 0, i_in = 0, f_in = 0, o_in = 0, a_in = 0, c_in = 0, c_out, h_out;
   logic [3:0] mode_in = 0;
   int cyc = 0, n_tests = 0, n_fail = 0, s_cyc;
   bit tmo, ovf_after_start;
   int t_acc[$], c_cyc[$], h_cyc[$], lo_cyc[$], rd_cyc[$];
   logic [31:0] c_log[$], h_log[$];
   int op_f[8], op_c[8], op_i[8], op_a[8], op_o[8], dly[8];

   model_convolutional_lstm_cell_update #(.DATA_SIZE(32), .CONTROL_SIZE(4), .FRACTION_SIZE(16)) dut (
      .CLK(clk), .RST(rst), .START(start), .READY(ready), .SIZE_L_IN(size_l), .MODE_IN(mode_in),
      .L_OUT_ENABLE(l_out_en), .L_IN_ENABLE(l_in_en), .I_IN(i_in), .F_IN(f_in), .O_IN(o_in),
      .A_IN(a_in), .C_IN(c_in), .C_OUT(c_out), .C_OUT_ENABLE(c_en), .H_OUT(h_out),
      .H_OUT_ENABLE(h_en), .OVERFLOW(ovf));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (c_en) begin c_log.push_back(c_out); c_cyc.push_back(cyc); end
      if (h_en) begin h_log.push_back(h_out); h_cyc.push_back(cyc); end
      if (l_out_en) lo_cyc.push_back(cyc);
      if (ready) rd_cyc.push_back(cyc);
   end

   function automatic longint clamp(input longint x, input longint lo, input longint hi);
      return x > hi ? hi : x < lo ? lo : x;
   endfunction

   // Reference: exact products, arithmetic shift, saturate, then activation and hidden product.
   function automatic void model(input int f, c, i, a, o, input bit m, output int co, output int ho, output bit ov);
      longint s, act, ph;
      s = ((longint'(f) * longint'(c)) >>> 16) + ((longint'(i) * longint'(a)) >>> 16);
      ov = s != clamp(s, MINV, MAXV);
      s = clamp(s, MINV, MAXV);
      co = int'(s);
      act = m ? s : clamp(s, -65536, 65536);
      ph = (longint'(o) * act) >>> 16;
      ov = ov | (ph != clamp(ph, MINV, MAXV));
      ho = int'(clamp(ph, MINV, MAXV));
   endfunction

   function automatic int rnd_val();
      return ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      t_acc.delete(); c_cyc.delete(); h_cyc.delete(); lo_cyc.delete(); rd_cyc.delete();
      c_log.delete(); h_log.delete();
   endtask

   task automatic run(input int l, input bit m);
      int n;
      clear_logs();
      tmo = 0;
      step();
      start = 1; size_l = l; mode_in = {3'($urandom), m}; s_cyc = cyc;
      step();
      start = 0; size_l = $urandom; ovf_after_start = ovf;
      for (int k = 0; k < l; k++) begin
         n = 0;
         while (l_out_en !== 1'b1 && n < 50) begin step(); n++; end
         if (n >= 50) begin tmo = 1; return; end
         repeat (dly[k]) step();
         {f_in, c_in, i_in, a_in, o_in} = {op_f[k], op_c[k], op_i[k], op_a[k], op_o[k]};
         l_in_en = 1; t_acc.push_back(cyc);
         step();
         l_in_en = 0;
         {f_in, c_in, i_in, a_in, o_in} = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
      n = 0;
      while (rd_cyc.size() == 0 && n < 50) begin step(); n++; end
      if (n >= 50) tmo = 1;
   endtask

   task automatic test_reset();
      n_tests++;
      if ({ready, l_out_en, c_en, h_en, ovf, c_out, h_out} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h required 0", {ready, l_out_en, c_en, h_en, ovf, c_out, h_out});
      end
      clear_logs();
      repeat (4) step();
      n_tests++;
      if (lo_cyc.size() + rd_cyc.size() + c_log.size() !== 0) begin
         n_fail++; $display("FAIL reset_idle_quiet: got %0d pulses required 0", lo_cyc.size() + rd_cyc.size() + c_log.size());
      end
   endtask

   task automatic test_basic(input bit m, input logic [31:0] eh);
      {op_f[0], op_c[0], op_i[0], op_a[0], op_o[0], dly[0]} = {32'h8000, 32'h20000, 32'h10000, 32'h4000, 32'h8000, 32'd0};
      run(1, m);
      n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL basic_timeout m=%0d: got timeout required none", m); end
      n_tests++; if (c_log.size() !== 1 || h_log.size() !== 1) begin n_fail++; $display("FAIL basic_count m=%0d: got %0d/%0d required 1/1", m, c_log.size(), h_log.size()); end
      for (int k = 0; k < c_log.size() && k < 1; k++) begin
         n_tests++; if (c_log[k] !== 32'h14000) begin n_fail++; $display("FAIL basic_c m=%0d: got %h required 00014000", m, c_log[k]); end
      end
      for (int k = 0; k < h_log.size() && k < 1; k++) begin
         n_tests++; if (h_log[k] !== eh) begin n_fail++; $display("FAIL basic_h m=%0d: got %h required %h", m, h_log[k], eh); end
      end
      n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf m=%0d: got %b required 0", m, ovf); end
      n_tests++; if (rd_cyc.size() !== 1) begin n_fail++; $display("FAIL basic_ready m=%0d: got %0d pulses required 1", m, rd_cyc.size()); end
   endtask

   task automatic test_overflow();
      {op_f[0], op_c[0], op_i[0], op_a[0], op_o[0], dly[0]} = {32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0, 32'd0, 32'h10000, 32'd2};
      run(1, 0);
      n_tests++; if (c_log.size() !== 1) begin n_fail++; $display("FAIL ovf_count: got %0d required 1", c_log.size()); end
      for (int k = 0; k < c_log.size() && k < 1; k++) begin
         n_tests++; if (c_log[k] !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL ovf_c: got %h required 7fffffff", c_log[k]); end
      end
      for (int k = 0; k < h_log.size() && k < 1; k++) begin
         n_tests++; if (h_log[k] !== 32'h10000) begin n_fail++; $display("FAIL ovf_h: got %h required 00010000", h_log[k]); end
      end
      n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b required 1", ovf); end
      run(0, 0);
      n_tests++; if (ovf_after_start !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_at_start: got %b required 0", ovf_after_start); end
   endtask

   task automatic test_empty();
      run(0, 1);
      n_tests++; if (rd_cyc.size() !== 1) begin n_fail++; $display("FAIL empty_ready_count: got %0d required 1", rd_cyc.size()); end
      for (int k = 0; k < rd_cyc.size() && k < 1; k++) begin
         n_tests++; if (rd_cyc[k] !== s_cyc + 2) begin n_fail++; $display("FAIL empty_ready_cycle: got %0d required %0d", rd_cyc[k], s_cyc + 2); end
      end
      n_tests++; if (lo_cyc.size() + c_log.size() + h_log.size() !== 0) begin n_fail++; $display("FAIL empty_enables: got %0d pulses required 0", lo_cyc.size() + c_log.size() + h_log.size()); end
   endtask

   task automatic test_stream(input int l, input bit m, input bit chk_time, input string nm);
      int ec, eh;
      bit eo, any_ov;
      any_ov = 0;
      run(l, m);
      n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL %s_timeout: got timeout required none", nm); end
      n_tests++; if (c_log.size() !== l || h_log.size() !== l || lo_cyc.size() !== l) begin
         n_fail++; $display("FAIL %s_counts: got c=%0d h=%0d lout=%0d required %0d each", nm, c_log.size(), h_log.size(), lo_cyc.size(), l);
      end
      for (int k = 0; k < l; k++) begin
         model(op_f[k], op_c[k], op_i[k], op_a[k], op_o[k], m, ec, eh, eo);
         any_ov |= eo;
         if (k < c_log.size()) begin
            n_tests++; if (c_log[k] !== 32'(ec)) begin n_fail++; $display("FAIL %s_c[%0d]: got %h required %h", nm, k, c_log[k], ec); end
         end
         if (k < h_log.size()) begin
            n_tests++; if (h_log[k] !== 32'(eh)) begin n_fail++; $display("FAIL %s_h[%0d]: got %h required %h", nm, k, h_log[k], eh); end
         end
         if (chk_time && k < c_cyc.size() && k < h_cyc.size() && k < lo_cyc.size() && k < t_acc.size()) begin
            n_tests++; if (c_cyc[k] !== t_acc[k] + 2) begin n_fail++; $display("FAIL %s_c_time[%0d]: got %0d required %0d", nm, k, c_cyc[k], t_acc[k] + 2); end
            n_tests++; if (h_cyc[k] !== t_acc[k] + 3) begin n_fail++; $display("FAIL %s_h_time[%0d]: got %0d required %0d", nm, k, h_cyc[k], t_acc[k] + 3); end
            n_tests++; if (lo_cyc[k] !== (k == 0 ? s_cyc + 1 : t_acc[k-1] + 3)) begin
               n_fail++; $display("FAIL %s_lout_time[%0d]: got %0d required %0d", nm, k, lo_cyc[k], k == 0 ? s_cyc + 1 : t_acc[k-1] + 3);
            end
         end
      end
      n_tests++; if (ovf !== any_ov) begin n_fail++; $display("FAIL %s_ovf: got %b required %b", nm, ovf, any_ov); end
      if (rd_cyc.size() > 0 && t_acc.size() == l) begin
         n_tests++; if (rd_cyc[0] !== t_acc[l-1] + 4) begin n_fail++; $display("FAIL %s_ready_time: got %0d required %0d", nm, rd_cyc[0], t_acc[l-1] + 4); end
      end
   endtask

   task automatic test_delays();
      for (int k = 0; k < 4; k++) {op_f[k], op_c[k], op_i[k], op_a[k], op_o[k]} = {rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val()};
      {dly[0], dly[1], dly[2], dly[3]} = {32'd0, 32'd5, 32'd1, 32'd3};
      test_stream(4, 1'($urandom), 1, "delays");
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 8; k++) begin
            {op_f[k], op_c[k], op_i[k], op_a[k], op_o[k]} = {rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val()};
            dly[k] = $urandom_range(0, 3);
         end
         test_stream($urandom_range(1, 6), 1'($urandom), 1, "random");
      end
   endtask

   task automatic test_reset_mid_run();
      int n, nlo;
      clear_logs();
      step();
      start = 1; size_l = 4; mode_in = 0;
      step();
      start = 0;
      for (int k = 0; k < 2; k++) begin
         n = 0;
         while (l_out_en !== 1'b1 && n < 50) begin step(); n++; end
         {f_in, c_in, i_in, a_in, o_in} = {rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val()};
         l_in_en = 1;
         step();
         l_in_en = 0;
      end
      n = 0;
      while (c_log.size() < 2 && n < 50) begin step(); n++; end
      n_tests++; if (c_log.size() !== 2) begin n_fail++; $display("FAIL abort_second_c: got %0d c pulses required 2", c_log.size()); end
      rst = 1;
      step();
      rst = 0;
      n_tests++;
      if ({ready, l_out_en, c_en, h_en, ovf, c_out, h_out} !== '0) begin
         n_fail++; $display("FAIL abort_outputs: got %h required 0", {ready, l_out_en, c_en, h_en, ovf, c_out, h_out});
      end
      nlo = lo_cyc.size();
      repeat (6) step();
      n_tests++; if (rd_cyc.size() !== 0 || lo_cyc.size() !== nlo || c_log.size() !== 2) begin
         n_fail++; $display("FAIL abort_quiet: got ready=%0d lout=%0d c=%0d required 0/%0d/2", rd_cyc.size(), lo_cyc.size(), c_log.size(), nlo);
      end
      test_basic(0, 32'h8000);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 0;
      test_reset();
      test_basic(0, 32'h8000);
      test_basic(1, 32'hA000);
      test_overflow();
      test_empty();
      test_delays();
      test_random();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
